rom_download_bridge: RTL and testbench
======================================

Name: rom_download_bridge

Overview:
- Sits directly upstream of the SoC's ROM download port.
- Converts the MiSTer HPS ioctl 16-bit word download stream into the byte-wide dn_addr/dn_wr/dn_data write strobes that load the 4 KB program ROM.
- Back-pressures the HPS with ioctl_wait while a word is being serialised.
- Holds the CPU in reset during a download and for a programmable tail afterwards, so the CPU never fetches from a half-loaded ROM.

Parameters:
- ROM_BYTES, 4096: bytes accepted. Bytes at address >= ROM_BYTES are discarded.
- ROM_INDEX, 8'd0: ioctl_index value that selects this ROM; other indices are ignored.
- HOLD_TAIL, 256: clk_sys cycles cpu_hold stays high after ioctl_download falls (1..65535).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  single-cycle strobe: ioctl_addr/ioctl_dout valid.
- ioctl_addr  in  25  byte address of the word; bit 0 is ignored (word aligned).
- ioctl_dout  in  16  data word; [7:0] goes to the even byte, [15:8] to the odd byte.
- ioctl_wait  out  1  high while the bridge cannot accept a new ioctl_wr.
- dn_addr  out  14  ROM byte write address.
- dn_wr  out  1  ROM byte write strobe, one cycle per byte.
- dn_data  out  8  ROM byte write data.
- cpu_hold  out  1  CPU reset request.
- loaded  out  1  sticky: at least one complete download has finished.
- err  out  1  sticky: protocol violation or overflow seen during the current download.

Behaviour:
- Reset values: ioctl_wait=0, dn_wr=0, dn_addr=0, dn_data=0, cpu_hold=1, loaded=0, err=0, FSM=IDLE, tail counter=0.
- After reset, cpu_hold stays high for HOLD_TAIL cycles, then drops, even if no download ever occurs.
- sel = ioctl_download && (ioctl_index == ROM_INDEX).
- FSM IDLE:
  - On ioctl_wr && sel: latch word, latch base = {ioctl_addr[13:1],1'b0}, latch the in-range flag per byte; set ioctl_wait=1 on the next edge; go to LO.
  - ioctl_wr with !sel: ignored, no state change.
- FSM LO (1 cycle):
  - dn_addr=base, dn_data=word[7:0].
  - dn_wr=1 only if base < ROM_BYTES.
  - Go to HI.
- FSM HI (1 cycle):
  - dn_addr=base+1, dn_data=word[15:8].
  - dn_wr=1 only if base+1 < ROM_BYTES.
  - ioctl_wait=0 on exit; go to IDLE.
- Latency: ioctl_wr at cycle N gives LO byte write at N+1 and HI byte write at N+2. The bridge can accept the next ioctl_wr at N+3.
- dn_wr is a registered output, high exactly one cycle per written byte. dn_addr and dn_data are stable whenever dn_wr=1.
- Addressing and overflow:
  - Address range check uses the full 25-bit ioctl_addr, not the truncated value.
  - Any byte with address >= ROM_BYTES is dropped and sets err.
- ioctl_wr while FSM != IDLE (ignoring ioctl_wait):
  - The write is discarded and err is set.
  - The in-flight word completes unchanged.
- Download start (rising edge of sel): cpu_hold=1 next cycle, err cleared, tail counter cleared.
- Download end (falling edge of ioctl_download while sel was active):
  - If the FSM is mid-word, the word still completes.
  - The tail counter starts once the FSM is IDLE and ioctl_download=0.
  - cpu_hold drops on the cycle the counter reaches HOLD_TAIL.
  - loaded is set the same cycle and stays set until reset.
- A new download starting during the tail re-asserts cpu_hold, and the tail restarts at the next download end.
- Reset asserted mid-word: the word is abandoned, with no further dn_wr, and all outputs return to their reset values.
- Writes to any other ioctl_index never produce dn_wr and never affect cpu_hold.

Test Plan:
- Basic word write: download idx0, ioctl_wr addr=0x000010, dout=0xBEEF -> dn_wr at N+1 (addr 0x010, data 0xEF) and N+2 (addr 0x011, data 0xBE); ioctl_wait high for N+1..N+2.
- Full 4 KB stream: 2048 words honouring ioctl_wait -> 4096 dn_wr pulses, ROM readback matches, err=0. cpu_hold falls exactly 256 cycles after download falls, loaded=1.
- Overflow: word at addr 0x000FFE, then addr 0x001000 -> bytes 0xFFE and 0xFFF written; the second word produces no dn_wr, err=1.
- Protocol violation: second ioctl_wr one cycle after the first -> first word written intact, second dropped, err=1.
- Index filter and tail restart:
  - Download idx=1 with writes -> no dn_wr, cpu_hold unaffected.
  - New idx0 download 100 cycles into the tail -> cpu_hold stays high, then 256 cycles after the new end it drops.
- Reset mid-word: reset asserted in the LO cycle -> no HI write, ioctl_wait=0, cpu_hold=1, loaded=0, err=0 next cycle.

Source files
------------

// File: rtl/rom_download_bridge.sv
// ----------------------------------------------------------------------------
// rom_download_bridge
//
// Purpose:
//   Sits in front of the SoC program-ROM download port. It turns the MiSTer
//   HPS ioctl 16-bit word stream into byte-wide dn_addr/dn_wr/dn_data write
//   strobes. The HPS is back-pressured with ioctl_wait while a word is being
//   serialised. The CPU is held in reset during a download and for HOLD_TAIL
//   cycles after it ends, so it never fetches from a half-loaded ROM.
//
// Parameters:
//   ROM_BYTES  bytes accepted; bytes at address >= ROM_BYTES are dropped
//   ROM_INDEX  ioctl_index value that selects this ROM
//   HOLD_TAIL  clk_sys cycles cpu_hold stays high after the download ends
//
// Ports:
//   clk_sys         in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   ioctl_download  in   HPS download active
//   ioctl_index     in   [7:0]  download target index
//   ioctl_wr        in   single-cycle word strobe
//   ioctl_addr      in   [24:0] byte address of the word (bit 0 ignored)
//   ioctl_dout      in   [15:0] word; [7:0] even byte, [15:8] odd byte
//   ioctl_wait      out  high while a new ioctl_wr cannot be accepted
//   dn_addr         out  [13:0] ROM byte address
//   dn_wr           out  ROM byte write strobe, one cycle per byte
//   dn_data         out  [7:0] ROM byte data
//   cpu_hold        out  CPU reset request
//   loaded          out  sticky: a complete download has finished
//   err             out  sticky per download: protocol violation or overflow
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a selected ioctl_wr; no byte write pending
//   ST_LO   | even byte of the latched word is on dn_* this cycle
//   ST_HI   | odd byte of the latched word is on dn_* this cycle
// ----------------------------------------------------------------------------
module rom_download_bridge #(
  parameter int         ROM_BYTES = 4096,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter int         HOLD_TAIL = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic [13:0] dn_addr,
  output logic        dn_wr,
  output logic [7:0]  dn_data,
  output logic        cpu_hold,
  output logic        loaded,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  // Range limit is one bit wider than the full ioctl byte address so the
  // compare never truncates an oversized address into the ROM window.
  localparam logic [25:0] ROM_LIMIT = 26'(ROM_BYTES);
  localparam logic [15:0] TAIL_END  = 16'(HOLD_TAIL);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,      state_d;
  logic [12:0] word_addr_q,  word_addr_d;   // ROM word address of latched word
  logic [7:0]  hi_byte_q,    hi_byte_d;     // odd byte waiting for ST_LO->ST_HI
  logic        hi_ok_q,      hi_ok_d;       // odd byte lies inside the ROM
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        dn_wr_q,      dn_wr_d;
  logic [13:0] dn_addr_q,    dn_addr_d;
  logic [7:0]  dn_data_q,    dn_data_d;
  logic        cpu_hold_q,   cpu_hold_d;
  logic        loaded_q,     loaded_d;
  logic        err_q,        err_d;
  logic        sel_q,        sel_d;         // sel one cycle ago, for edge detect
  logic        dl_seen_q,    dl_seen_d;     // a download ran since the last tail
  logic [15:0] tail_cnt_q,   tail_cnt_d;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic        sel;
  logic        sel_rise;
  logic        wr_accept;
  logic        wr_violation;
  logic [25:0] lo_byte_addr;
  logic [25:0] hi_byte_addr;
  logic        lo_in_range;
  logic        hi_in_range;
  logic        tail_run;
  logic [15:0] tail_next;
  logic        addr_bit0_unused;

  // Words are always aligned; the HPS sets bit 0 to zero.
  assign addr_bit0_unused = ioctl_addr[0];

  assign sel          = ioctl_download && (ioctl_index == ROM_INDEX);
  assign sel_rise     = sel && !sel_q;
  assign wr_accept    = ioctl_wr && sel && (state_q == ST_IDLE);
  assign wr_violation = ioctl_wr && sel && (state_q != ST_IDLE);

  assign lo_byte_addr = {1'b0, ioctl_addr[24:1], 1'b0};
  assign hi_byte_addr = {1'b0, ioctl_addr[24:1], 1'b1};
  assign lo_in_range  = lo_byte_addr < ROM_LIMIT;
  assign hi_in_range  = hi_byte_addr < ROM_LIMIT;

  // The tail only advances once the last word has drained and the download
  // is over. Other indices do not pause it, so they cannot stretch cpu_hold.
  assign tail_run  = cpu_hold_q && !sel && (state_q == ST_IDLE);
  assign tail_next = tail_cnt_q + 16'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    hi_byte_d    = hi_byte_q;
    hi_ok_d      = hi_ok_q;
    ioctl_wait_d = ioctl_wait_q;
    dn_wr_d      = 1'b0;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    cpu_hold_d   = cpu_hold_q;
    loaded_d     = loaded_q;
    err_d        = err_q;
    sel_d        = sel;
    dl_seen_d    = dl_seen_q;
    tail_cnt_d   = tail_cnt_q;

    // Byte serialiser. dn_* are registered, so the even byte is loaded on the
    // accepting edge and appears during ST_LO; the odd byte appears in ST_HI.
    case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          state_d      = ST_LO;
          word_addr_d  = ioctl_addr[13:1];
          hi_byte_d    = ioctl_dout[15:8];
          hi_ok_d      = hi_in_range;
          ioctl_wait_d = 1'b1;
          dn_wr_d      = lo_in_range;
          dn_addr_d    = {ioctl_addr[13:1], 1'b0};
          dn_data_d    = ioctl_dout[7:0];
        end
      end
      ST_LO: begin
        state_d   = ST_HI;
        dn_wr_d   = hi_ok_q;
        dn_addr_d = {word_addr_q, 1'b1};
        dn_data_d = hi_byte_q;
      end
      ST_HI: begin
        state_d      = ST_IDLE;
        ioctl_wait_d = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        ioctl_wait_d = 1'b0;
      end
    endcase

    // err is per download: cleared at the start, then sticky. A write landing
    // in the same cycle as the start still counts against the new download.
    if (sel_rise) begin
      err_d = 1'b0;
    end
    if (wr_violation || (wr_accept && !(lo_in_range && hi_in_range))) begin
      err_d = 1'b1;
    end

    // CPU hold and tail timer. A new download restarts the tail from zero even
    // if the previous tail was still running.
    if (sel_rise) begin
      cpu_hold_d = 1'b1;
      tail_cnt_d = 16'd0;
      dl_seen_d  = 1'b1;
    end else if (tail_run) begin
      tail_cnt_d = tail_next;
      if (tail_next == TAIL_END) begin
        cpu_hold_d = 1'b0;
        // The post-reset tail runs without any download and must not mark
        // the ROM as loaded.
        loaded_d   = loaded_q | dl_seen_q;
        dl_seen_d  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_addr_q  <= 13'd0;
      hi_byte_q    <= 8'd0;
      hi_ok_q      <= 1'b0;
      ioctl_wait_q <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= 14'd0;
      dn_data_q    <= 8'd0;
      cpu_hold_q   <= 1'b1;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      sel_q        <= 1'b0;
      dl_seen_q    <= 1'b0;
      tail_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      hi_byte_q    <= hi_byte_d;
      hi_ok_q      <= hi_ok_d;
      ioctl_wait_q <= ioctl_wait_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      cpu_hold_q   <= cpu_hold_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      sel_q        <= sel_d;
      dl_seen_q    <= dl_seen_d;
      tail_cnt_q   <= tail_cnt_d;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign loaded     = loaded_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rom_download_bridge.sv
// ----------------------------------------------------------------------------
// tb_rom_download_bridge
//
// Self-checking bench for rom_download_bridge. Inputs are driven 1 time unit
// after each rising edge; the byte-write monitor samples on the falling edge.
// The reference model works at the transaction level: each accepted word
// turns into up to two expected (address, byte) writes in a queue, a shadow
// ROM array, a sticky error flag and a "bridge busy for 3 cycles" budget.
// ----------------------------------------------------------------------------
module tb_rom_download_bridge;

  localparam int ROM_BYTES = 4096;
  localparam int HOLD_TAIL = 256;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [15:0] ioctl_dout = 16'd0;
  logic        ioctl_wait;
  logic [13:0] dn_addr;
  logic        dn_wr;
  logic [7:0]  dn_data;
  logic        cpu_hold;
  logic        loaded;
  logic        err;

  rom_download_bridge #(
    .ROM_BYTES(ROM_BYTES),
    .ROM_INDEX(8'd0),
    .HOLD_TAIL(HOLD_TAIL)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .dn_addr       (dn_addr),
    .dn_wr         (dn_wr),
    .dn_data       (dn_data),
    .cpu_hold      (cpu_hold),
    .loaded        (loaded),
    .err           (err)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [21:0] exp_q[$];              // {byte address[13:0], data[7:0]}
  logic [7:0]  rom_exp  [0:ROM_BYTES-1];
  logic [7:0]  rom_seen [0:16383];
  int          dn_wr_count = 0;
  bit          exp_err = 1'b0;
  bit          cur_sel = 1'b0;
  int          busy_left = 0;         // cycles (incl. current) bridge is busy

  // Byte-write monitor and scoreboard.
  logic [21:0] mon_e;
  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      dn_wr_count++;
      rom_seen[dn_addr] = dn_data;
      check_val("dn_wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_val("dn_addr", 32'(dn_addr), 32'(mon_e[21:8]));
        check_val("dn_data", 32'(dn_data), 32'(mon_e[7:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (busy_left > 0) busy_left--;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_dl(input bit on, input logic [7:0] idx);
    bit new_sel;
    ioctl_download = on;
    ioctl_index    = idx;
    new_sel = on && (idx == 8'd0);
    if (new_sel && !cur_sel) exp_err = 1'b0;
    cur_sel = new_sel;
  endtask

  // Expected effect of one accepted word, computed from byte addresses.
  task automatic model_word(input logic [24:0] a, input logic [15:0] d);
    logic [31:0] ba;
    logic [7:0]  bv;
    for (int b = 0; b < 2; b++) begin
      ba = {7'd0, a[24:1], 1'b0} + 32'(b);
      bv = (b == 0) ? d[7:0] : d[15:8];
      if (ba < 32'(ROM_BYTES)) begin
        exp_q.push_back({ba[13:0], bv});
        rom_exp[ba] = bv;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // Drive one ioctl_wr cycle regardless of ioctl_wait.
  task automatic send_raw(input logic [24:0] a, input logic [15:0] d);
    check_val("ioctl_wait_vs_model", 32'(ioctl_wait), 32'(busy_left > 0));
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (cur_sel) begin
      if (busy_left > 0) exp_err = 1'b1;
      else begin
        busy_left = 3;
        model_word(a, d);
      end
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Honour ioctl_wait, with a bounded wait.
  task automatic send_word(input logic [24:0] a, input logic [15:0] d);
    int g = 0;
    while (ioctl_wait === 1'b1 && g < 10) begin
      tick();
      g++;
    end
    if (g >= 10) check_val("ioctl_wait_timeout", 32'(ioctl_wait), 32'd0);
    send_raw(a, d);
  endtask

  task automatic drain();
    while (busy_left > 0) tick();
    tick();
  endtask

  // Call in the cycle in which the download has just been dropped (or reset
  // released); counts cycles until cpu_hold is seen low.
  task automatic wait_hold_drop(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (cpu_hold === 1'b1 && n < HOLD_TAIL + 20);
    check_val(tag, 32'(n), 32'(HOLD_TAIL));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(3);
    exp_q.delete();
    busy_left = 0;
    exp_err   = 1'b0;
  endtask

  // Global time limit.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] d1;
    logic [15:0] d2;
    logic [24:0] ra;
    int          c0;
    int          mism;

    for (int i = 0; i < ROM_BYTES; i++) rom_exp[i] = 8'd0;
    for (int i = 0; i < 16384; i++) rom_seen[i] = 8'd0;

    // Reset values and post-reset tail
    do_reset();
    check_val("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    check_val("rst_dn_wr",      32'(dn_wr),      32'd0);
    check_val("rst_dn_addr",    32'(dn_addr),    32'd0);
    check_val("rst_dn_data",    32'(dn_data),    32'd0);
    check_val("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    check_val("rst_loaded",     32'(loaded),     32'd0);
    check_val("rst_err",        32'(err),        32'd0);
    reset = 1'b0;
    wait_hold_drop("tail_after_reset");
    check_val("loaded_no_download", 32'(loaded), 32'd0);

    // Basic word with exact latency
    set_dl(1'b1, 8'd0);
    tick();
    check_val("start_cpu_hold", 32'(cpu_hold), 32'd1);
    send_raw(25'h000010, 16'hBEEF);
    check_val("basic_n1_wait", 32'(ioctl_wait), 32'd1);
    check_val("basic_n1_wr",   32'(dn_wr),      32'd1);
    check_val("basic_n1_addr", 32'(dn_addr),    32'h010);
    check_val("basic_n1_data", 32'(dn_data),    32'hEF);
    tick();
    check_val("basic_n2_wait", 32'(ioctl_wait), 32'd1);
    check_val("basic_n2_wr",   32'(dn_wr),      32'd1);
    check_val("basic_n2_addr", 32'(dn_addr),    32'h011);
    check_val("basic_n2_data", 32'(dn_data),    32'hBE);
    tick();
    check_val("basic_n3_wait", 32'(ioctl_wait), 32'd0);
    check_val("basic_n3_wr",   32'(dn_wr),      32'd0);
    drain();
    set_dl(1'b0, 8'd0);
    wait_hold_drop("tail_basic");
    check_val("loaded_basic", 32'(loaded), 32'd1);

    // Full 4 KB stream, random data and random gaps
    set_dl(1'b1, 8'd0);
    tick();
    check_val("stream_cpu_hold", 32'(cpu_hold), 32'd1);
    c0 = dn_wr_count;
    for (int w = 0; w < ROM_BYTES / 2; w++) begin
      ticks($urandom_range(0, 2));
      send_word(25'(2 * w), 16'($urandom));
    end
    drain();
    check_val("stream_dn_wr_count", 32'(dn_wr_count - c0), 32'(ROM_BYTES));
    check_val("stream_err", 32'(err), 32'(exp_err));
    check_val("stream_pending", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < ROM_BYTES; i++)
      if (rom_seen[i] !== rom_exp[i]) mism++;
    check_val("stream_rom_readback", 32'(mism), 32'd0);
    set_dl(1'b0, 8'd0);
    wait_hold_drop("tail_stream");
    check_val("loaded_stream", 32'(loaded), 32'd1);

    // Overflow, including an address that aliases into the ROM if truncated
    set_dl(1'b1, 8'd0);
    tick();
    check_val("ovf_err_cleared", 32'(err), 32'd0);
    send_word(25'h000FFE, 16'($urandom));
    drain();
    check_val("ovf_err_in_range", 32'(err), 32'(exp_err));
    send_word(25'h001000, 16'($urandom));
    drain();
    check_val("ovf_err_set", 32'(err), 32'(exp_err));
    send_word(25'h1000010, 16'($urandom));
    drain();
    check_val("ovf_pending", 32'(exp_q.size()), 32'd0);
    set_dl(1'b0, 8'd0);
    tick();

    // Protocol violation: second write one cycle after the first
    set_dl(1'b1, 8'd0);
    tick();
    check_val("viol_err_cleared", 32'(err), 32'd0);
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    send_raw(25'h000020, d1);
    send_raw(25'h000040, d2);
    drain();
    check_val("viol_err", 32'(err), 32'(exp_err));
    check_val("viol_pending", 32'(exp_q.size()), 32'd0);
    check_val("viol_lo_byte", 32'(rom_seen[14'h020]), 32'(d1[7:0]));
    check_val("viol_hi_byte", 32'(rom_seen[14'h021]), 32'(d1[15:8]));

    // Random burst in the same download, ignoring ioctl_wait
    for (int k = 0; k < 300; k++) begin
      ticks($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = 25'($urandom);
      else ra = 25'($urandom_range(0, 16'h1FFF));
      send_raw(ra, 16'($urandom));
    end
    drain();
    check_val("rand_err", 32'(err), 32'(exp_err));
    check_val("rand_pending", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < ROM_BYTES; i++)
      if (rom_seen[i] !== rom_exp[i]) mism++;
    check_val("rand_rom_readback", 32'(mism), 32'd0);
    set_dl(1'b0, 8'd0);
    wait_hold_drop("tail_random");

    // Index filter: other index never writes and never moves cpu_hold
    set_dl(1'b1, 8'd1);
    tick();
    check_val("idx1_cpu_hold_start", 32'(cpu_hold), 32'd0);
    for (int k = 0; k < 6; k++) begin
      send_word(25'(2 * k + 25'h300), 16'($urandom));
      check_val("idx1_cpu_hold", 32'(cpu_hold), 32'd0);
    end
    set_dl(1'b0, 8'd0);
    ticks(5);
    check_val("idx1_cpu_hold_end", 32'(cpu_hold), 32'd0);
    check_val("idx1_err", 32'(err), 32'(exp_err));

    // Tail restart: new download 100 cycles into the tail
    set_dl(1'b1, 8'd0);
    tick();
    send_word(25'h000100, 16'($urandom));
    drain();
    set_dl(1'b0, 8'd0);
    ticks(100);
    check_val("restart_mid_tail_hold", 32'(cpu_hold), 32'd1);
    set_dl(1'b1, 8'd0);
    for (int k = 0; k < 4; k++) begin
      ticks(60);
      check_val("restart_hold_in_dl", 32'(cpu_hold), 32'd1);
    end
    send_word(25'h000102, 16'($urandom));
    drain();
    set_dl(1'b0, 8'd0);
    wait_hold_drop("tail_restart");
    check_val("restart_loaded", 32'(loaded), 32'd1);

    // Reset in the LO cycle: HI byte abandoned, outputs back to reset values
    set_dl(1'b1, 8'd0);
    tick();
    send_raw(25'h000200, 16'($urandom));
    reset = 1'b1;
    tick();
    exp_q.delete();
    busy_left = 0;
    exp_err   = 1'b0;
    check_val("rstmid_dn_wr",    32'(dn_wr),      32'd0);
    check_val("rstmid_wait",     32'(ioctl_wait), 32'd0);
    check_val("rstmid_cpu_hold", 32'(cpu_hold),   32'd1);
    check_val("rstmid_loaded",   32'(loaded),     32'd0);
    check_val("rstmid_err",      32'(err),        32'd0);
    tick();
    set_dl(1'b0, 8'd0);
    reset = 1'b0;
    wait_hold_drop("tail_after_midword_reset");
    check_val("rstmid_loaded_after_tail", 32'(loaded), 32'd0);
    check_val("rstmid_pending", 32'(exp_q.size()), 32'd0);

    ticks(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
